// File: rtl/calc_pkg.sv
// Shared widths, limits and FSM state type for the calculator display path.
package calc_pkg;

    localparam int unsigned BIN_W      = 14;
    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned CONV_STEPS = 14;
    localparam int unsigned CNT_W      = 4;

    localparam logic [BIN_W-1:0] MAX_DEC    = 14'd9999;
    localparam logic [BCD_W-1:0] SAT_DIGITS = 16'h9999;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StConv = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, one double-dabble step per clock.
// Values above 9999 saturate the display to 9999 and raise overflow.
module bin_to_bcd_seq
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0
);

    state_e           state_q, state_d;
    logic [BIN_W-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [BCD_W-1:0] digits_q, digits_d;

    logic [BCD_W-1:0]         adj;
    logic [BCD_W+BIN_W:0]     shifted;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    // Bit BCD_W+BIN_W is the carry out of the thousands digit; only possible above 9999.
    assign shifted = {adj, shreg_q, 1'b0};

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        digits_d   = digits_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StConv;
                    shreg_d    = bin_in;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (bin_in > MAX_DEC);
                end
            end
            StConv: begin
                scratch_d = shifted[BCD_W+BIN_W-1:BIN_W];
                shreg_d   = shifted[BIN_W-1:0];
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == CNT_W'(CONV_STEPS - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    ovf_d   = ovf_pend_q;
                    if (ovf_pend_q || shifted[BCD_W+BIN_W]) begin
                        digits_d = SAT_DIGITS;
                    end else begin
                        digits_d = shifted[BCD_W+BIN_W-1:BIN_W];
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
        end
    end

    assign busy     = (state_q == StConv);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign d3       = digits_q[15:12];
    assign d2       = digits_q[11:8];
    assign d1       = digits_q[7:4];
    assign d0       = digits_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed vector table, multi-cycle corner
// sequences and a random sweep against an arithmetic decimal/saturate model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  d3, d2, d1, d0;

    int n_checks;
    int n_fail;
    int cur_val;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] exp_d;
        logic        exp_o;
    } vec_t;

    vec_t vecs[8];

    bin_to_bcd_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .d3       (d3),
        .d2       (d2),
        .d1       (d1),
        .d0       (d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_digits(input int v);
        logic [3:0] t, h, te, u;
        if (v > 9999) return 16'h9999;
        t  = 4'(v / 1000);
        h  = 4'((v / 100) % 10);
        te = 4'((v / 10) % 10);
        u  = 4'(v % 10);
        return {t, h, te, u};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (bin_in=%0d): got %0h want %0h", name, cur_val, got, exp);
        end
    endtask

    // Drive a one-cycle start pulse; returns #1 after its rising edge.
    task automatic start_pulse(input int v);
        start  = 1'b1;
        bin_in = 14'(v);
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Counts edges until done is seen; also counts cycles where busy dropped early.
    task automatic wait_done(output int lat, output int busy_gaps);
        lat       = 0;
        busy_gaps = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) return;
            if (!busy) busy_gaps++;
        end
        chk("done_timeout", 32'(lat), 32'd14);
    endtask

    task automatic run_one(input int v, input logic [15:0] exp_d, input logic exp_o);
        int lat, gaps;
        cur_val = v;
        start_pulse(v);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done(lat, gaps);
        chk("latency", 32'(lat), 32'd14);
        chk("busy_gaps", 32'(gaps), 32'd0);
        chk("digits", 32'({d3, d2, d1, d0}), 32'(exp_d));
        chk("overflow", 32'(overflow), 32'(exp_o));
        chk("busy_in_done", 32'(busy), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("done_single", 32'(done), 32'd0);
        chk("digits_hold", 32'({d3, d2, d1, d0}), 32'(exp_d));
        chk("overflow_hold", 32'(overflow), 32'(exp_o));
    endtask

    initial begin
        int lat, gaps, dcount, v;
        n_checks = 0;
        n_fail   = 0;
        cur_val  = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bin_in   = '0;

        vecs[0] = '{bin: 14'd0,     exp_d: 16'h0000, exp_o: 1'b0};
        vecs[1] = '{bin: 14'd1234,  exp_d: 16'h1234, exp_o: 1'b0};
        vecs[2] = '{bin: 14'd198,   exp_d: 16'h0198, exp_o: 1'b0};
        vecs[3] = '{bin: 14'd9999,  exp_d: 16'h9999, exp_o: 1'b0};
        vecs[4] = '{bin: 14'd10000, exp_d: 16'h9999, exp_o: 1'b1};
        vecs[5] = '{bin: 14'd16383, exp_d: 16'h9999, exp_o: 1'b1};
        vecs[6] = '{bin: 14'd5,     exp_d: 16'h0005, exp_o: 1'b0};
        vecs[7] = '{bin: 14'd8765,  exp_d: 16'h8765, exp_o: 1'b0};

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_digits", 32'({d3, d2, d1, d0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_one(int'(vecs[i].bin), vecs[i].exp_d, vecs[i].exp_o);
        end

        // Start re-pulsed at E5 is ignored; start in the done cycle is accepted.
        cur_val = 1234;
        start_pulse(1234);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start_pulse(42);
        wait_done(lat, gaps);
        chk("ignore_latency", 32'(lat), 32'd9);
        chk("ignore_digits", 32'({d3, d2, d1, d0}), 32'h1234);
        cur_val = 42;
        start_pulse(42);
        wait_done(lat, gaps);
        chk("b2b_latency", 32'(lat), 32'd14);
        chk("b2b_digits", 32'({d3, d2, d1, d0}), 32'h0042);
        chk("b2b_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset mid-conversion.
        cur_val = 1234;
        start_pulse(1234);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_digits", 32'({d3, d2, d1, d0}), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        chk("midrst_no_done", 32'(dcount), 32'd0);
        run_one(7, 16'h0007, 1'b0);

        // Random sweep against the decimal/saturate model.
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 16383));
            if (i % 4 == 0) v = int'($urandom_range(9990, 10010));
            run_one(v, ref_digits(v), (v > 9999));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
